iter_shifter: RTL and testbench

- Parametrised multi-cycle shift unit for the execute stage; successor to the fixed shift-left-by-1 block.
- Performs SLL, SRL, SRA and ROL by a runtime shift amount, moving up to STEP bit positions per clock.
- Accepts operations with a start/busy/done handshake, so the RISC-V pipeline can use it for shift instructions without a full barrel shifter.

---
 rtl/iter_shifter.sv | 104 ++++++++++
 tb/tb_iter_shifter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit for the execute stage.
// Moves up to STEP bit positions per clock under a start/busy/done handshake.
`timescale 1ns/1ps
module iter_shifter #(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         out
);

  localparam int W = $clog2(N);
  // one extra bit so STEP == N still fits
  localparam logic [W:0] STEP_L = (W+1)'(STEP);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_data;
  logic [N-1:0] r_out;
  logic [W-1:0] r_rem;
  logic [1:0]   r_opr;
  logic         r_done;
  logic [N-1:0] w_shifted;
  logic [W:0]   w_rem;
  logic [W:0]   w_k;
  logic         w_last;

  assign w_rem  = {1'b0, r_rem};
  assign w_last = (w_rem <= STEP_L);
  assign w_k    = w_last ? w_rem : STEP_L;

  // small mux over counts 0..STEP instead of a full barrel
  always_comb begin
    w_shifted = r_data;
    for (int c = 0; c <= STEP; c++) begin
      if (w_k == (W+1)'(c)) begin
        unique case (r_opr)
          2'b00:   w_shifted = r_data << c;
          2'b01:   w_shifted = r_data >> c;
          2'b10:   w_shifted = N'($signed(r_data) >>> c);
          default: w_shifted = (r_data << c)
                             | (r_data >> (N - c));
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rem  <= '0;
      r_opr  <= '0;
      r_out  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_data <= in;
          r_rem  <= shamt;
          r_opr  <= op;
        end
      end else begin
        r_data <= w_shifted;
        r_rem  <= r_rem - w_k[W-1:0];
        if (w_last) begin
          r_out  <= w_shifted;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed-vector bench for iter_shifter (N=32, STEP=4).
// Inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_iter_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] in = '0;
  logic [4:0]  shamt = '0;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_chk  = 0;
  int n_pass = 0;

  iter_shifter #(.N(32), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in    (in),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h",
                  tag, obs, exp);
  endtask

  // Issue one op at a falling edge; return at the falling
  // edge of the done cycle (or after a cycle budget).
  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [31:0] d,
                       input logic [4:0] s,
                       input logic [31:0] exp,
                       input int lat);
    int n;
    start = 1'b1; op = o; in = d; shamt = s;
    @(negedge clk);
    start = 1'b0; in = $urandom; shamt = 5'($urandom);
    op = 2'($urandom);
    n = 1;
    while (!done && n < 40) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, " lat"}, 32'(n), 32'(lat));
    chk({tag, " out"}, out, exp);
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] held;

    // 1. reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; in = $urandom;
      shamt = 5'($urandom); op = 2'($urandom);
      @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst out", out, 32'h0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in = $urandom;
    end
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst out", out, 32'h0);

    // 2. long SLL
    do_op("sll31", SLL, 32'h1, 5'd31, 32'h80000000, 9);

    // done lasts one cycle; out holds while idle
    held = out;
    repeat (3) begin
      @(negedge clk);
      in = $urandom;
      chk("done pulse", 32'(done), 32'd0);
      chk("out hold", out, held);
    end

    // 3. sign and rotate
    do_op("sra4", SRA, 32'h800000F0, 5'd4, 32'hF800000F, 2);
    do_op("srl4", SRL, 32'h800000F0, 5'd4, 32'h0800000F, 2);
    do_op("rol1", ROL, 32'h80000001, 5'd1, 32'h00000003, 2);
    do_op("sra31", SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9);
    do_op("rol12", ROL, 32'h12345678, 5'd12, 32'h45678123, 4);
    do_op("srl5", SRL, 32'hFFFFFFFF, 5'd5, 32'h07FFFFFF, 3);
    do_op("sll7", SLL, 32'h0000ABCD, 5'd7, 32'h0055E680, 3);
    do_op("sra9p", SRA, 32'h7FFFF000, 5'd9, 32'h003FFFF8, 4);

    // 4. zero shift
    do_op("sra0", SRA, 32'h12345678, 5'd0, 32'h12345678, 2);

    // 5. start while busy ignored, then back-to-back
    start = 1'b1; op = SLL; in = 32'h1; shamt = 5'd9;
    @(negedge clk);
    chk("hs busy", 32'(busy), 32'd1);
    start = 1'b1; op = SRL; in = 32'hFFFF0000; shamt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hs lat", 32'(n), 32'd4);
    chk("hs out", out, 32'h00000200);
    do_op("b2b", SRL, 32'hF0, 5'd4, 32'h0000000F, 2);

    // 6. reset mid-operation
    start = 1'b1; op = SLL; in = 32'h1; shamt = 5'd31;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst out", out, 32'h0);
    chk("mid-rst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("no done after rst", 32'(pulses), 32'd0);
    chk("out after rst", out, 32'h0);
    do_op("after-rst", ROL, 32'hF0000000, 5'd4, 32'h0000000F, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
